fir_tree_accumulator: RTL

- Parametrised successor to the FIR adder-tree accumulator. Sums TAPS signed multiplier products through a binary adder tree with configurable pipeline register spacing.
- The exact full-precision sum is then rounded, shifted and optionally saturated to OUTBITS.
- Sits between the tap-multiplier array and the filter output port.
- Adds a ready/valid handshake with whole-pipeline stall, an asynchronous reset and a per-sample saturation flag.

---
 rtl/fir_tree_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fir_tree_accumulator.sv
// fir_tree_accumulator: sums TAPS signed products through a binary adder tree
// with a pipeline register bank every REG_EVERY levels (and always after the
// root), then rounds, shifts and optionally saturates into OUTBITS.
//
// Handshake: a beat moves on a rising edge when valid && ready. One global
// advance enable en = !out_valid || out_ready moves every stage at once;
// in_ready = en. When en is low every data and valid register holds, so
// nothing is lost, duplicated or reordered. Bubbles travel as invalid stages.
module fir_tree_accumulator #(
  parameter int TAPS      = 401,
  parameter int MULTBITS  = 32,
  parameter int OUTBITS   = 32,
  parameter int SHIFT     = 0,
  parameter int REG_EVERY = 1,
  parameter int SATURATE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [MULTBITS-1:0] multiplier_out [0:TAPS-1],
  output logic signed [OUTBITS-1:0]  out,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int EXTB = $clog2(TAPS);
  localparam int AW   = MULTBITS + EXTB;      // full-precision sum width
  localparam int P    = 1 << EXTB;            // leaves padded to a power of two
  localparam int LOGP = $clog2(P);
  localparam int S    = (LOGP + REG_EVERY - 1) / REG_EVERY;
  localparam int RW   = AW + 1;               // room for the rounding add

  localparam logic signed [RW-1:0] MAXV = {{(RW-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUTBITS+1){1'b1}}, {(OUTBITS-1){1'b0}}};
  localparam logic signed [OUTBITS-1:0] OMAX = {1'b0, {(OUTBITS-1){1'b1}}};
  localparam logic signed [OUTBITS-1:0] OMIN = {1'b1, {(OUTBITS-1){1'b0}}};

  logic                      en;
  logic [S:1]                vld_q;
  logic                      ovld_q;
  logic signed [OUTBITS-1:0] out_q, out_d;
  logic                      sat_q, sat_d;
  logic signed [RW-1:0]      sum_ext, r;
  logic                      hi, lo;

  assign en       = !ovld_q || out_ready;
  assign in_ready = en;

  // Level k of the tree has P>>k nodes; level 0 is the sign-extended products.
  for (genvar k = 0; k <= LOGP; k++) begin : g_lvl
    localparam int N = P >> k;
    logic signed [AW-1:0] node [0:N-1];
    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_tap
        if (i < TAPS) begin : g_used
          assign node[i] = {{EXTB{multiplier_out[i][MULTBITS-1]}}, multiplier_out[i]};
        end else begin : g_pad
          assign node[i] = '0;
        end
      end
    end else begin : g_add
      logic signed [AW-1:0] sum_d [0:N-1];
      for (genvar i = 0; i < N; i++) begin : g_pair
        assign sum_d[i] = g_lvl[k-1].node[2*i] + g_lvl[k-1].node[2*i+1];
      end
      if ((k % REG_EVERY == 0) || (k == LOGP)) begin : g_reg
        // Pipeline bank for this level; advances only with the global enable.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < N; i++) node[i] <= '0;
          end else if (en) begin
            for (int i = 0; i < N; i++) node[i] <= sum_d[i];
          end
        end
      end else begin : g_comb
        assign node = sum_d;
      end
    end
  end

  // Valid bits travel alongside the tree register banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[1] <= in_valid;
      for (int s = 2; s <= S; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  assign sum_ext = {g_lvl[LOGP].node[0][AW-1], g_lvl[LOGP].node[0]};

  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
    // Round half toward +inf, then arithmetic shift.
    assign r = (sum_ext + HALF) >>> SHIFT;
  end else begin : g_nornd
    assign r = sum_ext;
  end

  // Clamp to the signed OUTBITS range, or wrap by truncation.
  always_comb begin
    hi    = r > MAXV;
    lo    = r < MINV;
    out_d = r[OUTBITS-1:0];
    sat_d = 1'b0;
    if (SATURATE != 0) begin
      if (hi) begin
        out_d = OMAX;
        sat_d = 1'b1;
      end else if (lo) begin
        out_d = OMIN;
        sat_d = 1'b1;
      end
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovld_q <= 1'b0;
      out_q  <= '0;
      sat_q  <= 1'b0;
    end else if (en) begin
      ovld_q <= vld_q[S];
      out_q  <= out_d;
      sat_q  <= sat_d;
    end
  end

  assign out       = out_q;
  assign out_sat   = sat_q;
  assign out_valid = ovld_q;

endmodule
